// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler and period counter feeding NUM_CH
// compare channels, with shadowed compare/TOP registers loaded at period boundaries.
module pwm_bank #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 10,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [15:0]       wr_data,
   input  logic              ena,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_stb
);

   logic [NUM_CH-1:0][CNT_W-1:0] cmp_pend_q, cmp_pend_d;
   logic [NUM_CH-1:0][CNT_W-1:0] cmp_act_q, cmp_act_d;
   logic [CNT_W-1:0]             top_pend_q, top_pend_d;
   logic [CNT_W-1:0]             top_act_q, top_act_d;
   logic [DIV_W-1:0]             div_q, div_d;
   logic [DIV_W-1:0]             psc_q, psc_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         dir_dn_q, dir_dn_d;
   logic                         mode_q, mode_d;
   logic [NUM_CH-1:0]            pol_q, pol_d;
   logic [NUM_CH-1:0]            pwm_q, pwm_d;
   logic                         stb_q, stb_d;

   logic             div_wr, top_wr, ctrl_wr, tick, boundary;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dir_dn_nxt;

   always_comb begin
      div_wr  = wr_en && (wr_addr == 4'd8);
      top_wr  = wr_en && (wr_addr == 4'd9);
      ctrl_wr = wr_en && (wr_addr == 4'd10);

      cmp_pend_d = cmp_pend_q;
      for (int ch = 0; ch < NUM_CH; ch++)
         if (wr_en && (wr_addr == 4'(ch)))
            cmp_pend_d[ch] = wr_data[CNT_W-1:0];
      top_pend_d = top_wr  ? wr_data[CNT_W-1:0]  : top_pend_q;
      div_d      = div_wr  ? wr_data[DIV_W-1:0]  : div_q;
      mode_d     = ctrl_wr ? wr_data[15]         : mode_q;
      pol_d      = ctrl_wr ? wr_data[NUM_CH-1:0] : pol_q;

      tick  = ena && (psc_q == div_q);
      psc_d = (!ena || div_wr || tick) ? '0 : psc_q + 1'b1;

      // Next count on a tick; direction flips back to up whenever 0 is reached.
      cnt_nxt    = cnt_q;
      dir_dn_nxt = dir_dn_q;
      if (!mode_q) begin
         cnt_nxt = (cnt_q >= top_act_q) ? '0 : cnt_q + 1'b1;
      end else if (top_act_q == '0) begin
         cnt_nxt = '0;
      end else if (!dir_dn_q && (cnt_q < top_act_q)) begin
         cnt_nxt = cnt_q + 1'b1;
      end else begin
         cnt_nxt    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
         dir_dn_nxt = 1'b1;
      end
      if (cnt_nxt == '0) dir_dn_nxt = 1'b0;

      cnt_d     = cnt_q;
      dir_dn_d  = dir_dn_q;
      cmp_act_d = cmp_act_q;
      top_act_d = top_act_q;
      boundary  = 1'b0;
      if (!ena) begin
         cnt_d     = '0;
         dir_dn_d  = 1'b0;
         cmp_act_d = cmp_pend_q;
         top_act_d = top_pend_q;
      end else if (ctrl_wr) begin
         cnt_d    = '0;
         dir_dn_d = 1'b0;
      end else if (tick) begin
         cnt_d    = cnt_nxt;
         dir_dn_d = dir_dn_nxt;
         boundary = (cnt_nxt == '0);
         if (boundary) begin
            cmp_act_d = cmp_pend_q;
            top_act_d = top_pend_q;
         end
      end

      for (int ch = 0; ch < NUM_CH; ch++)
         pwm_d[ch] = ena ? ((cnt_q < cmp_act_q[ch]) ^ pol_q[ch]) : pol_q[ch];
      stb_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_pend_q <= '0;
         cmp_act_q  <= '0;
         top_pend_q <= '1;
         top_act_q  <= '1;
         div_q      <= '0;
         psc_q      <= '0;
         cnt_q      <= '0;
         dir_dn_q   <= 1'b0;
         mode_q     <= 1'b0;
         pol_q      <= '0;
         pwm_q      <= '0;
         stb_q      <= 1'b0;
      end else begin
         cmp_pend_q <= cmp_pend_d;
         cmp_act_q  <= cmp_act_d;
         top_pend_q <= top_pend_d;
         top_act_q  <= top_act_d;
         div_q      <= div_d;
         psc_q      <= psc_d;
         cnt_q      <= cnt_d;
         dir_dn_q   <= dir_dn_d;
         mode_q     <= mode_d;
         pol_q      <= pol_d;
         pwm_q      <= pwm_d;
         stb_q      <= stb_d;
      end
   end

   assign pwm_out    = pwm_q;
   assign period_stb = stb_q;

endmodule
